lsu_ctrl: RTL and testbench
===========================

# lsu_ctrl

Load/store controller sitting between the execute stage and the word-organised data memory. It accepts one byte/halfword/word load or store request at a time. It converts each request into word-addressed memory accesses with byte enables, shifted write data and a read strobe. For loads it extracts and sign/zero-extends the result from the returned word(s). Accesses that straddle a 32-bit word boundary are split into two consecutive word accesses.

## Interface
Parameters:
- none. Access codes `ALU_LB`, `ALU_LBU`, `ALU_LH`, `ALU_LHU`, `ALU_LW`, `ALU_SB`, `ALU_SH`, `ALU_SW` come from `define.vh`.

Ports:
- clk  in  1  single clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  high only in IDLE; accept = req_valid && req_ready at a rising edge
- is_store  in  1  1 = store, 0 = load
- alucode  in  6  access code from `define.vh`
- addr  in  32  byte address
- wdata  in  32  store data, right-aligned
- resp_valid  out  1  one-cycle completion pulse, for loads and stores
- rdata  out  32  extended load result, valid with resp_valid; 0 for stores
- misalign_err  out  1  valid with resp_valid; see Configuration
- mem_addr  out  32  word-aligned byte address, bits [1:0] always 0
- mem_we  out  4  byte write enables, bit i covers bits [8i+7:8i]
- mem_wdata  out  32  lane-aligned write data
- mem_re  out  1  read strobe
- mem_rdata  in  32  read word, valid the cycle after mem_re

## Operation
- Size n: 1 for LB/LBU/SB, 2 for LH/LHU/SH, 4 otherwise.
- Unknown alucode is treated as LW when is_store=0 and as SW when is_store=1.
- The address, code, data and a split flag are latched at accept. off = addr[1:0]; split = (off + n > 4).
- States:
  - IDLE → A0 on accept.
  - A0 → A1 if split; else CAP for a load, RESP for a store.
  - A1 → CAP for a load, RESP for a store.
  - CAP → RESP.
  - RESP → IDLE.
- A0:
  - mem_addr = {addr[31:2], 2'b00}.
  - Store: mem_we = (mask << off)[3:0], with mask = 4'b0001 / 4'b0011 / 4'b1111. mem_wdata = wdata << 8·off.
  - Load: mem_re = 1.
- A1:
  - mem_addr = A0 address + 4, modulo 2^32 (0xFFFFFFFC wraps to 0).
  - Store: mem_we = mask >> (4 − off); mem_wdata = wdata >> 8·(4 − off).
  - Load: mem_re = 1; word0 = mem_rdata is captured.
- CAP:
  - Captures word1 = mem_rdata when split, otherwise word0.
  - Then computes ({word1, word0} >> 8·off) truncated to n bytes, sign-extended for LB/LH and zero-extended for LBU/LHU/LW.
- mem_we = 0 and mem_re = 0 in IDLE, CAP and RESP, and in A0/A1 for the opposite access type.
- Reset (asynchronous, any state):
  - State → IDLE.
  - All outputs → 0, except req_ready → 1.
  - A split store interrupted after A0 leaves the first word written; this is accepted behaviour.
- req_valid is ignored outside IDLE. The request fields need not be held after accept.

## Timing
- Accept at edge T. Cycle k means the cycle after edge T+k.
- Non-split store: write in cycle 1; resp_valid in cycle 2.
- Split store: writes in cycles 1–2; resp_valid in cycle 3.
- Non-split load: mem_re in cycle 1; resp_valid in cycle 3.
- Split load: mem_re in cycles 1–2; resp_valid in cycle 4.
- Next accept is possible at the edge ending the RESP cycle + 1 (req_ready rises in IDLE).
- All outputs are registered or decoded from state and latched fields only. There is no combinational path from req_* to mem_*.

## Configuration
- `LSU_MISALIGN_EN` defined:
  - Boundary-crossing accesses are split as above.
  - misalign_err is tied to 0.
- Not defined:
  - A request with split = 1 goes IDLE → RESP with no memory access.
  - resp_valid = 1, misalign_err = 1, rdata = 0 in cycle 1.
  - Non-split requests behave identically to the defined case.

## Test plan
- SW at addr 0x100, wdata 0xDEADBEEF → cycle 1: mem_addr 0x100, mem_we 4'b1111, mem_wdata 0xDEADBEEF; resp_valid in cycle 2.
- SB at addr 0x203, wdata 0x000000A5 → mem_addr 0x200, mem_we 4'b1000, mem_wdata 0xA5000000.
- Memory word at 0x300 = 0x8077F0E1:
  - LB at 0x301 → rdata 0xFFFFFFF0.
  - LBU at 0x301 → rdata 0x000000F0.
  - LH at 0x302 → rdata 0xFFFF8077.
- With `LSU_MISALIGN_EN`, SW at 0x7FE, wdata 0x11223344:
  - mem_we 4'b1100, data 0x33440000 at 0x7FC.
  - Then mem_we 4'b0011, data 0x00001122 at 0x800.
  - resp_valid in cycle 3.
- With `LSU_MISALIGN_EN`, words 0x7FC = 0xAABBCCDD and 0x800 = 0x11223344, LW at 0x7FD → rdata 0x44AABBCC, resp_valid in cycle 4.
- Edge cases:
  - Without the macro, LH at 0x3 → resp_valid and misalign_err in cycle 1, mem_we and mem_re never set.
  - rst_n low during A1 of a split store → mem_we = 0 and req_ready = 1 immediately.

Source files
------------

// File: rtl/lsu_if.sv
// lsu_if: request/response handshake and word-memory bus for lsu_ctrl.
// The slave modport is the controller's view; the master modport is the
// view of whoever issues requests and owns the data memory.
interface lsu_if;
  logic        req_valid;
  logic        req_ready;
  logic        is_store;
  logic [5:0]  alucode;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        resp_valid;
  logic [31:0] rdata;
  logic        misalign_err;
  logic [31:0] mem_addr;
  logic [3:0]  mem_we;
  logic [31:0] mem_wdata;
  logic        mem_re;
  logic [31:0] mem_rdata;

  modport slave (
    input  req_valid, is_store, alucode, addr, wdata, mem_rdata,
    output req_ready, resp_valid, rdata, misalign_err,
           mem_addr, mem_we, mem_wdata, mem_re
  );

  modport master (
    output req_valid, is_store, alucode, addr, wdata, mem_rdata,
    input  req_ready, resp_valid, rdata, misalign_err,
           mem_addr, mem_we, mem_wdata, mem_re
  );
endinterface

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: byte/halfword/word load-store controller in front of a
// word-organised data memory. Word-crossing accesses are split into two
// word accesses when LSU_MISALIGN_EN is defined; otherwise they complete
// at once with misalign_err and touch no memory.
`ifndef ALU_LB
`define ALU_LB  6'd11
`define ALU_LH  6'd12
`define ALU_LW  6'd13
`define ALU_LBU 6'd14
`define ALU_LHU 6'd15
`define ALU_SB  6'd16
`define ALU_SH  6'd17
`define ALU_SW  6'd18
`endif

module lsu_ctrl (
  input  logic  clk,
  input  logic  rst_n,
  lsu_if.slave  bus
);

  typedef enum logic [2:0] {S_IDLE, S_A0, S_A1, S_CAP, S_RESP} state_e;

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] word0_q, word0_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  size_q, size_d;
  logic        sign_q, sign_d;
  logic        store_q, store_d;
  logic        split_q, split_d;
  logic        misalign_q, misalign_d;

  logic [1:0]  req_size;
  logic        req_sign;
  logic        req_split;
  logic        accept;

  logic [1:0]  off;
  logic [4:0]  bit_off;
  logic [3:0]  mask;
  logic [7:0]  we_wide;
  logic [63:0] wdata_wide;
  logic [63:0] rd_wide;
  logic [31:0] rd_shift;
  logic [31:0] load_ext;
  logic [31:0] base_addr;

  // Decode the incoming request: size code (0=byte,1=half,2=word), signedness, split
  always_comb begin
    req_size = 2'd2;
    req_sign = 1'b0;
    case (bus.alucode)
      `ALU_LB:          begin req_size = 2'd0; req_sign = 1'b1; end
      `ALU_LBU, `ALU_SB: req_size = 2'd0;
      `ALU_LH:          begin req_size = 2'd1; req_sign = 1'b1; end
      `ALU_LHU, `ALU_SH: req_size = 2'd1;
      default:          req_size = 2'd2;
    endcase
    case (req_size)
      2'd0:    req_split = 1'b0;
      2'd1:    req_split = (bus.addr[1:0] == 2'b11);
      default: req_split = (bus.addr[1:0] != 2'b00);
    endcase
    accept = bus.req_valid && (state_q == S_IDLE);
  end

  // State and latched request fields
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      word0_q    <= '0;
      rdata_q    <= '0;
      size_q     <= '0;
      sign_q     <= 1'b0;
      store_q    <= 1'b0;
      split_q    <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      word0_q    <= word0_d;
      rdata_q    <= rdata_d;
      size_q     <= size_d;
      sign_q     <= sign_d;
      store_q    <= store_d;
      split_q    <= split_d;
      misalign_q <= misalign_d;
    end
  end

  // Next-state sequencing through the one or two word accesses
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
`ifdef LSU_MISALIGN_EN
          state_d = S_A0;
`else
          state_d = req_split ? S_RESP : S_A0;
`endif
        end
      end
      S_A0:    state_d = split_q ? S_A1 : (store_q ? S_RESP : S_CAP);
      S_A1:    state_d = store_q ? S_RESP : S_CAP;
      S_CAP:   state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Lane alignment of store data/enables and extraction of load data
  always_comb begin
    off        = addr_q[1:0];
    bit_off    = {off, 3'b000};
    base_addr  = {addr_q[31:2], 2'b00};
    case (size_q)
      2'd0:    mask = 4'b0001;
      2'd1:    mask = 4'b0011;
      default: mask = 4'b1111;
    endcase
    we_wide    = {4'b0000, mask} << off;
    wdata_wide = {32'd0, wdata_q} << bit_off;
    rd_wide    = split_q ? {bus.mem_rdata, word0_q} : {32'd0, bus.mem_rdata};
    rd_shift   = rd_wide[bit_off +: 32];
    case (size_q)
      2'd0:    load_ext = sign_q ? {{24{rd_shift[7]}}, rd_shift[7:0]}
                                 : {24'd0, rd_shift[7:0]};
      2'd1:    load_ext = sign_q ? {{16{rd_shift[15]}}, rd_shift[15:0]}
                                 : {16'd0, rd_shift[15:0]};
      default: load_ext = rd_shift;
    endcase
  end

  // Latch the request at accept, the first word in A1, the result in CAP
  always_comb begin
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    word0_d    = word0_q;
    rdata_d    = rdata_q;
    size_d     = size_q;
    sign_d     = sign_q;
    store_d    = store_q;
    split_d    = split_q;
    misalign_d = misalign_q;
    if (accept) begin
      addr_d  = bus.addr;
      wdata_d = bus.wdata;
      size_d  = req_size;
      sign_d  = req_sign;
      store_d = bus.is_store;
      split_d = req_split;
      rdata_d = '0;
`ifdef LSU_MISALIGN_EN
      misalign_d = 1'b0;
`else
      misalign_d = req_split;
`endif
    end
    if (state_q == S_A1) word0_d = bus.mem_rdata;
    if (state_q == S_CAP) rdata_d = load_ext;
  end

  // Outputs decoded from state and latched fields only
  always_comb begin
    bus.req_ready    = (state_q == S_IDLE);
    bus.resp_valid   = (state_q == S_RESP);
    bus.misalign_err = (state_q == S_RESP) && misalign_q;
    bus.rdata        = rdata_q;
    bus.mem_addr     = '0;
    bus.mem_we       = '0;
    bus.mem_wdata    = '0;
    bus.mem_re       = 1'b0;
    if (state_q == S_A0) begin
      bus.mem_addr = base_addr;
      if (store_q) begin
        bus.mem_we    = we_wide[3:0];
        bus.mem_wdata = wdata_wide[31:0];
      end else begin
        bus.mem_re = 1'b1;
      end
    end else if (state_q == S_A1) begin
      bus.mem_addr = base_addr + 32'd4;
      if (store_q) begin
        bus.mem_we    = we_wide[7:4];
        bus.mem_wdata = wdata_wide[63:32];
      end else begin
        bus.mem_re = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: directed bench for lsu_ctrl with a small byte-enabled word
// memory model. Split-access checks follow LSU_MISALIGN_EN.
`ifndef ALU_LB
`define ALU_LB  6'd11
`define ALU_LH  6'd12
`define ALU_LW  6'd13
`define ALU_LBU 6'd14
`define ALU_LHU 6'd15
`define ALU_SB  6'd16
`define ALU_SH  6'd17
`define ALU_SW  6'd18
`endif

module tb_lsu_ctrl;

  logic clk;
  logic rst_n;
  int   compared;
  int   mismatched;
  logic [31:0] mem [0:1023];

  lsu_if bus ();

  lsu_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // Free-running clock, 10 time units per cycle
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Word memory: registered read data, byte-enabled writes, preset words on reset
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 32'd0;
      mem[32'h300 >> 2] <= 32'h8077F0E1;
      mem[32'h7FC >> 2] <= 32'hAABBCCDD;
      mem[32'h800 >> 2] <= 32'h11223344;
      bus.mem_rdata     <= 32'd0;
    end else begin
      if (bus.mem_re) bus.mem_rdata <= mem[bus.mem_addr[11:2]];
      for (int b = 0; b < 4; b++)
        if (bus.mem_we[b]) mem[bus.mem_addr[11:2]][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Present one request for one edge, then scramble the request fields
  task automatic applyStimulus(input logic st, input logic [5:0] code,
                               input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.is_store  = st;
    bus.alucode   = code;
    bus.addr      = a;
    bus.wdata     = d;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    bus.is_store  = ~st;
    bus.alucode   = 6'd0;
    bus.addr      = 32'hFFFF_FFFF;
    bus.wdata     = 32'h5A5A_5A5A;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // Directed sequence; each block starts at accept and steps one cycle at a time
  initial begin
    compared      = 0;
    mismatched    = 0;
    rst_n         = 1'b0;
    bus.req_valid = 1'b0;
    bus.is_store  = 1'b0;
    bus.alucode   = 6'd0;
    bus.addr      = 32'd0;
    bus.wdata     = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_req_ready", bus.req_ready, 1);
    checkOutput("rst_resp_valid", bus.resp_valid, 0);
    checkOutput("rst_mem_we", bus.mem_we, 0);
    checkOutput("rst_mem_re", bus.mem_re, 0);
    checkOutput("rst_rdata", bus.rdata, 0);
    checkOutput("rst_misalign", bus.misalign_err, 0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] SW 0x100");
    applyStimulus(1'b1, `ALU_SW, 32'h100, 32'hDEADBEEF);
    checkOutput("sw_c1_addr", bus.mem_addr, 32'h100);
    checkOutput("sw_c1_we", bus.mem_we, 4'b1111);
    checkOutput("sw_c1_wdata", bus.mem_wdata, 32'hDEADBEEF);
    checkOutput("sw_c1_ready", bus.req_ready, 0);
    checkOutput("sw_c1_resp", bus.resp_valid, 0);
    nextCycle();
    checkOutput("sw_c2_resp", bus.resp_valid, 1);
    checkOutput("sw_c2_we", bus.mem_we, 0);
    checkOutput("sw_c2_rdata", bus.rdata, 0);
    checkOutput("sw_c2_err", bus.misalign_err, 0);
    nextCycle();
    checkOutput("sw_c3_resp", bus.resp_valid, 0);
    checkOutput("sw_c3_ready", bus.req_ready, 1);
    checkOutput("sw_mem", mem[32'h100 >> 2], 32'hDEADBEEF);

    $display("[TB] SB 0x203");
    applyStimulus(1'b1, `ALU_SB, 32'h203, 32'h000000A5);
    checkOutput("sb_c1_addr", bus.mem_addr, 32'h200);
    checkOutput("sb_c1_we", bus.mem_we, 4'b1000);
    checkOutput("sb_c1_wdata", bus.mem_wdata, 32'hA5000000);
    nextCycle();
    checkOutput("sb_c2_resp", bus.resp_valid, 1);
    nextCycle();

    $display("[TB] SH 0x102");
    applyStimulus(1'b1, `ALU_SH, 32'h102, 32'h0000BEEF);
    checkOutput("sh_c1_addr", bus.mem_addr, 32'h100);
    checkOutput("sh_c1_we", bus.mem_we, 4'b1100);
    checkOutput("sh_c1_wdata", bus.mem_wdata, 32'hBEEF0000);
    nextCycle();
    checkOutput("sh_c2_resp", bus.resp_valid, 1);
    nextCycle();
    checkOutput("sh_mem", mem[32'h100 >> 2], 32'hBEEFBEEF);

    $display("[TB] LB 0x301");
    applyStimulus(1'b0, `ALU_LB, 32'h301, 32'h0);
    checkOutput("lb_c1_re", bus.mem_re, 1);
    checkOutput("lb_c1_addr", bus.mem_addr, 32'h300);
    checkOutput("lb_c1_we", bus.mem_we, 0);
    nextCycle();
    checkOutput("lb_c2_re", bus.mem_re, 0);
    checkOutput("lb_c2_resp", bus.resp_valid, 0);
    nextCycle();
    checkOutput("lb_c3_resp", bus.resp_valid, 1);
    checkOutput("lb_c3_rdata", bus.rdata, 32'hFFFFFFF0);
    nextCycle();
    checkOutput("lb_c4_resp", bus.resp_valid, 0);

    $display("[TB] LBU/LH/LHU/LW and unknown code");
    applyStimulus(1'b0, `ALU_LBU, 32'h301, 32'h0);
    nextCycle(); nextCycle();
    checkOutput("lbu_rdata", bus.rdata, 32'h000000F0);
    nextCycle();
    applyStimulus(1'b0, `ALU_LH, 32'h302, 32'h0);
    nextCycle(); nextCycle();
    checkOutput("lh_resp", bus.resp_valid, 1);
    checkOutput("lh_rdata", bus.rdata, 32'hFFFF8077);
    nextCycle();
    applyStimulus(1'b0, `ALU_LHU, 32'h302, 32'h0);
    nextCycle(); nextCycle();
    checkOutput("lhu_rdata", bus.rdata, 32'h00008077);
    nextCycle();
    applyStimulus(1'b0, 6'd63, 32'h300, 32'h0);
    checkOutput("unk_c1_re", bus.mem_re, 1);
    nextCycle(); nextCycle();
    checkOutput("unk_rdata", bus.rdata, 32'h8077F0E1);
    nextCycle();

`ifdef LSU_MISALIGN_EN
    $display("[TB] split LW 0x7FD");
    applyStimulus(1'b0, `ALU_LW, 32'h7FD, 32'h0);
    checkOutput("slw_c1_re", bus.mem_re, 1);
    checkOutput("slw_c1_addr", bus.mem_addr, 32'h7FC);
    nextCycle();
    checkOutput("slw_c2_re", bus.mem_re, 1);
    checkOutput("slw_c2_addr", bus.mem_addr, 32'h800);
    nextCycle();
    checkOutput("slw_c3_re", bus.mem_re, 0);
    checkOutput("slw_c3_resp", bus.resp_valid, 0);
    nextCycle();
    checkOutput("slw_c4_resp", bus.resp_valid, 1);
    checkOutput("slw_c4_rdata", bus.rdata, 32'h44AABBCC);
    checkOutput("slw_c4_err", bus.misalign_err, 0);
    nextCycle();

    $display("[TB] split SW 0x7FE");
    applyStimulus(1'b1, `ALU_SW, 32'h7FE, 32'h11223344);
    checkOutput("ssw_c1_addr", bus.mem_addr, 32'h7FC);
    checkOutput("ssw_c1_we", bus.mem_we, 4'b1100);
    checkOutput("ssw_c1_wdata", bus.mem_wdata, 32'h33440000);
    nextCycle();
    checkOutput("ssw_c2_addr", bus.mem_addr, 32'h800);
    checkOutput("ssw_c2_we", bus.mem_we, 4'b0011);
    checkOutput("ssw_c2_wdata", bus.mem_wdata, 32'h00001122);
    checkOutput("ssw_c2_resp", bus.resp_valid, 0);
    nextCycle();
    checkOutput("ssw_c3_resp", bus.resp_valid, 1);
    nextCycle();
    checkOutput("ssw_mem0", mem[32'h7FC >> 2], 32'h3344CCDD);
    checkOutput("ssw_mem1", mem[32'h800 >> 2], 32'h11221122);

    $display("[TB] reset during A1 of split store");
    applyStimulus(1'b1, `ALU_SW, 32'h7FE, 32'h55667788);
    nextCycle();
    checkOutput("rsta1_we_before", bus.mem_we, 4'b0011);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("rsta1_we", bus.mem_we, 0);
    checkOutput("rsta1_ready", bus.req_ready, 1);
    checkOutput("rsta1_addr", bus.mem_addr, 0);
`else
    $display("[TB] misaligned LH 0x3");
    applyStimulus(1'b0, `ALU_LH, 32'h3, 32'h0);
    checkOutput("mlh_c1_resp", bus.resp_valid, 1);
    checkOutput("mlh_c1_err", bus.misalign_err, 1);
    checkOutput("mlh_c1_rdata", bus.rdata, 0);
    checkOutput("mlh_c1_re", bus.mem_re, 0);
    checkOutput("mlh_c1_we", bus.mem_we, 0);
    nextCycle();
    checkOutput("mlh_c2_resp", bus.resp_valid, 0);
    checkOutput("mlh_c2_err", bus.misalign_err, 0);
    checkOutput("mlh_c2_ready", bus.req_ready, 1);

    $display("[TB] misaligned SW 0x7FE");
    applyStimulus(1'b1, `ALU_SW, 32'h7FE, 32'h11223344);
    checkOutput("msw_c1_resp", bus.resp_valid, 1);
    checkOutput("msw_c1_err", bus.misalign_err, 1);
    checkOutput("msw_c1_we", bus.mem_we, 0);
    nextCycle();
    checkOutput("msw_mem", mem[32'h7FC >> 2], 32'hAABBCCDD);

    $display("[TB] reset during A0 of store");
    applyStimulus(1'b1, `ALU_SW, 32'h400, 32'h12345678);
    checkOutput("rsta0_we_before", bus.mem_we, 4'b1111);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("rsta0_we", bus.mem_we, 0);
    checkOutput("rsta0_ready", bus.req_ready, 1);
    checkOutput("rsta0_addr", bus.mem_addr, 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    nextCycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
